input_spike_scanner: RTL and testbench
======================================

INPUT_SPIKE_SCANNER -- requirements
Module: input_spike_scanner

Interface
REQ-001 Parameter N_PIXELS, default 784, number of input pixels scanned per frame (28x28).
REQ-002 Parameter ADDR_W, default 10, width of ROM address and spike index.
REQ-003 Parameter FIFO_DEPTH, default 4, spike event buffer depth (power of 2, >=2).
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse: begin a frame scan; ignored unless state IDLE.
REQ-007 rom_addr  out  ADDR_W  address to the binary input ROM.
REQ-008 rom_q  in  1  ROM pixel bit, valid exactly one cycle after rom_addr (registered ROM read).
REQ-009 spk_valid  out  1  spike event available.
REQ-010 spk_ready  in  1  downstream neuron core accepts event.
REQ-011 spk_idx  out  ADDR_W  pixel index of the spiking input.
REQ-012 busy  out  1  high in SCAN or DRAIN.
REQ-013 done  out  1  one-cycle pulse at frame completion.

Function
REQ-014 States SHALL be IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after address N_PIXELS-1 issued; DRAIN->DONE when no read in flight and FIFO empty; DONE->IDLE unconditionally next cycle.
REQ-015 In SCAN, an address SHALL be issued (issue strobe) only when FIFO occupancy plus reads in flight < FIFO_DEPTH; otherwise rom_addr holds and scan stalls.
REQ-016 Addresses SHALL be issued in order 0..N_PIXELS-1, each exactly once per frame, no wrap.
REQ-017 The cycle after an issue, rom_q=1 SHALL push the issued address into the FIFO; rom_q=0 pushes nothing.
REQ-018 spk_valid SHALL equal FIFO non-empty; spk_idx SHALL be FIFO head; pop on spk_valid && spk_ready.
REQ-019 Simultaneous push and pop SHALL both take effect, including when FIFO full (pop frees slot) and when empty (push only).
REQ-020 Spike events SHALL leave in ascending index order, with no loss or duplication under any spk_ready pattern.
REQ-021 done SHALL assert for exactly one cycle, the cycle in DONE, after the last event is accepted.
REQ-022 start asserted while busy or in DONE SHALL be ignored.
REQ-023 Frame with no set pixels SHALL emit no events and still produce done.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, rom_addr 0, FIFO empty, spk_valid 0, spk_idx 0, busy 0, done 0, in-flight flag 0.
REQ-025 Reset mid-frame SHALL discard all buffered events; after release, block waits for a new start.

Configuration
REQ-026 Macro INPUT_SPIKE_COUNT_EN defined: output spike_count (ADDR_W bits) counts events accepted in the current frame, cleared on start and reset, held after done until the next start.
REQ-027 Macro undefined: spike_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package snn_input_pkg SHALL hold N_PIXELS default, ADDR_W default and the state enumeration.
REQ-029 FIFO SHALL be sub-module spike_event_fifo (parameterised width/depth, push/pop/full/empty/count); control FSM and address counter stay in the top module.

Verification
REQ-030 ROM with pixels 0, 5, 783 set, spk_ready=1 -> events 0, 5, 783 in order; done pulses once, after 783 accepted.
REQ-031 All-zero ROM, start -> no spk_valid; done within N_PIXELS+3 cycles of start.
REQ-032 All-ones ROM, spk_ready low for 50 cycles then high -> FIFO holds 4, scan stalls; 784 events 0..783 then delivered, no gaps/duplicates.
REQ-033 Random spk_ready (50%), sample-9 digit ROM -> event stream equals scoreboard list of set pixels; spike_count (if enabled) equals popcount.
REQ-034 rst_n pulsed low mid-SCAN at address 300 -> outputs at reset values immediately; new start rescans from address 0.
REQ-035 start pulsed during SCAN and during DONE -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/snn_input_pkg.sv
// rtl/snn_input_pkg.sv - shared defaults and scan state encoding for the input spike scanner
package snn_input_pkg;

    localparam int N_PIXELS_DEFAULT = 784;
    localparam int ADDR_W_DEFAULT   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - power-of-two spike event FIFO with occupancy count
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spike_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/input_spike_scanner.sv
// rtl/input_spike_scanner.sv - scans a binary input ROM and emits set-pixel indices as spike events
// Optional spike_count output enabled by defining INPUT_SPIKE_COUNT_EN.
module input_spike_scanner
    import snn_input_pkg::*;
#(
    parameter int N_PIXELS   = N_PIXELS_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_q,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [ADDR_W-1:0] spk_idx,
    output logic              busy,
    output logic              done
`ifdef INPUT_SPIKE_COUNT_EN
    ,
    output logic [ADDR_W-1:0] spike_count
`endif
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);
    localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic              in_flight;
    logic [ADDR_W-1:0] flight_addr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Reserve a slot for the read in flight so a pending hit can never overflow the FIFO.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    assign issue     = (state == ST_SCAN) && !fifo_full && (occupancy < DEPTH_V);
    assign push      = in_flight && rom_q;
    assign spk_valid = !fifo_empty;
    assign pop       = spk_valid && spk_ready;
    assign busy      = (state == ST_SCAN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    spike_event_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (flight_addr),
        .pop       (pop),
        .pop_data  (spk_idx),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SCAN;
            ST_SCAN:  if (issue && (rom_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!in_flight && fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // rom_addr always shows the next address to issue; it parks on the last one until the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            in_flight   <= 1'b0;
            flight_addr <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= issue;
            if (issue) begin
                flight_addr <= rom_addr;
                if (rom_addr != LAST_ADDR) begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                end
            end
            if (state == ST_DONE) begin
                rom_addr <= '0;
            end
        end
    end

`ifdef INPUT_SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count <= '0;
        end else if ((state == ST_IDLE) && start) begin
            spike_count <= '0;
        end else if (pop) begin
            spike_count <= spike_count + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_spike_scanner.sv
// tb/tb_input_spike_scanner.sv - randomized scoreboard bench for input_spike_scanner
module tb_input_spike_scanner;
    import snn_input_pkg::*;

    localparam int N  = 784;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rom_q = 1'b0;
    logic          spk_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] spk_idx;
    logic          spk_valid;
    logic          busy;
    logic          done;
`ifdef INPUT_SPIKE_COUNT_EN
    logic [AW-1:0] spike_count;
`endif

    bit rom_bits [1024];
    int exp_q [$];
    int ev_log [$];
    int n_checks = 0;
    int n_fail = 0;
    int ev_cnt = 0;
    int done_cnt = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    input_spike_scanner #(
        .N_PIXELS   (N),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .spk_valid   (spk_valid),
        .spk_ready   (spk_ready),
        .spk_idx     (spk_idx),
        .busy        (busy),
        .done        (done)
`ifdef INPUT_SPIKE_COUNT_EN
        ,
        .spike_count (spike_count)
`endif
    );

    // Registered ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_q <= rom_bits[rom_addr];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       spk_ready = 1'b1;
                1:       spk_ready = 1'($urandom_range(0, 1));
                default: spk_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_without_pending", int'(spk_valid && (exp_q.size() == 0)), 0);
            if (done) begin
                done_cnt++;
                check("done_after_last_event", exp_q.size(), 0);
            end
            if (spk_valid && spk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event_idx", spk_idx, -1);
                end else begin
                    check("event_idx", spk_idx, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                ev_log.push_back(int'(spk_idx));
                ev_cnt++;
            end
        end
    end

    // kind: 0 zeros, 1 ones, 2 pixels {0,5,783}, 3 digit nine, 4 random
    task automatic load_rom(input int kind);
        for (int i = 0; i < 1024; i++) rom_bits[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            int r;
            int c;
            int d;
            r = i / 28;
            c = i % 28;
            d = (r - 9) * (r - 9) + (c - 14) * (c - 14);
            case (kind)
                1:       rom_bits[i] = 1'b1;
                2:       rom_bits[i] = (i == 0) || (i == 5) || (i == 783);
                3:       rom_bits[i] = (d >= 20 && d <= 42) || (c >= 19 && c <= 21 && r >= 9 && r <= 24);
                4:       rom_bits[i] = ($urandom_range(0, 3) == 0);
                default: rom_bits[i] = 1'b0;
            endcase
        end
    endtask

    task automatic build_expect(output int n_exp);
        exp_q.delete();
        ev_log.delete();
        for (int i = 0; i < N; i++) if (rom_bits[i]) exp_q.push_back(i);
        n_exp = exp_q.size();
    endtask

    task automatic run_frame(input int mode, input bit poke_scan, input bit poke_done,
                             input int hold_low, output int cycles);
        int  d0;
        int  e0;
        int  n_exp;
        bit  seen;
        build_expect(n_exp);
        d0 = done_cnt;
        e0 = ev_cnt;
        ready_mode = (hold_low > 0) ? 2 : mode;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (hold_low > 0 && cycles == hold_low - 10) check("stall_addr_early", rom_addr, 4);
            if (hold_low > 0 && cycles == hold_low) begin
                check("stall_valid", spk_valid, 1);
                check("stall_head", spk_idx, 0);
                check("stall_addr", rom_addr, 4);
                check("stall_busy", busy, 1);
                ready_mode = mode;
            end
            if (poke_scan && cycles == 200) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                if (poke_done) begin
                    start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            end
        end
        check("done_seen", seen, 1);
        repeat (5) @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        check("event_count", ev_cnt - e0, n_exp);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_frame", busy, 0);
`ifdef INPUT_SPIKE_COUNT_EN
        check("spike_count", spike_count, n_exp);
`endif
        ready_mode = 0;
    endtask

    initial begin
        int cyc;
        int bad;
        int n_exp;
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_spk_idx", spk_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_waits_for_start", busy, 0);

        load_rom(2);
        run_frame(0, 1'b0, 1'b0, 0, cyc);
        check("sparse_events", ev_log.size(), 3);
        if (ev_log.size() == 3) begin
            check("sparse_ev0", ev_log[0], 0);
            check("sparse_ev1", ev_log[1], 5);
            check("sparse_ev2", ev_log[2], 783);
        end

        load_rom(0);
        run_frame(0, 1'b0, 1'b0, 0, cyc);
        check("zero_events", ev_log.size(), 0);
        check("zero_latency_within_bound", int'(cyc <= N + 3), 1);

        load_rom(1);
        run_frame(0, 1'b0, 1'b0, 50, cyc);
        check("ones_events", ev_log.size(), 784);
        bad = 0;
        for (int i = 0; i < ev_log.size(); i++) if (ev_log[i] != i) bad++;
        check("ones_gaps_or_dups", bad, 0);

        load_rom(3);
        run_frame(1, 1'b0, 1'b0, 0, cyc);

        for (int k = 0; k < 2; k++) begin
            load_rom(4);
            run_frame(1, 1'b0, 1'b0, 0, cyc);
        end

        load_rom(1);
        build_expect(n_exp);
        ready_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        while (rom_addr != 10'd300 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_addr_300", rom_addr, 300);
        rst_n = 1'b0;
        #1;
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_spk_valid", spk_valid, 0);
        check("midrst_spk_idx", spk_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
`ifdef INPUT_SPIKE_COUNT_EN
        check("midrst_spike_count", spike_count, 0);
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_no_valid", spk_valid, 0);
        check("post_rst_addr", rom_addr, 0);
        load_rom(4);
        run_frame(1, 1'b0, 1'b0, 0, cyc);

        load_rom(3);
        run_frame(1, 1'b1, 1'b1, 0, cyc);
        repeat (20) @(negedge clk);
        check("start_in_done_ignored", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
